// File: rtl/cache_read_controller_pkg.sv
// Shared state type and address-field width helpers for the direct-mapped read cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT
  } cache_state_e;

  function automatic int set_idx_bits(input int word_capacity, input int words_per_block);
    return $clog2(word_capacity / words_per_block);
  endfunction

  function automatic int word_idx_bits(input int words_per_block);
    return $clog2(words_per_block);
  endfunction

  function automatic int byte_idx_bits(input int word_width);
    return $clog2(word_width / 8);
  endfunction

endpackage

// File: rtl/cache_read_controller_addr_decoder.sv
// Splits a byte address into tag / set / word fields and the block-aligned base address.
module cache_addr_decoder
  import cache_pkg::*;
#(
  parameter int ADDR_BITS       = 32,
  parameter int WORD_BITS       = 32,
  parameter int WORD_CAPACITY   = 8,
  parameter int WORDS_PER_BLOCK = 4,
  localparam int SET_W  = set_idx_bits(WORD_CAPACITY, WORDS_PER_BLOCK),
  localparam int WORD_W = word_idx_bits(WORDS_PER_BLOCK),
  localparam int BYTE_W = byte_idx_bits(WORD_BITS),
  localparam int TAG_W  = ADDR_BITS - SET_W - WORD_W - BYTE_W
) (
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic [TAG_W-1:0]     o_tag,
  output logic [SET_W-1:0]     o_set,
  output logic [WORD_W-1:0]    o_word,
  output logic [ADDR_BITS-1:0] o_block_addr
);

  // Clears the word and byte offsets, leaving the address of word 0 of the block.
  localparam logic [ADDR_BITS-1:0] BLOCK_MASK = ~((ADDR_BITS'(1) << (WORD_W + BYTE_W)) - ADDR_BITS'(1));

  assign o_word       = i_addr[BYTE_W +: WORD_W];
  assign o_set        = i_addr[BYTE_W + WORD_W +: SET_W];
  assign o_tag        = i_addr[ADDR_BITS-1 -: TAG_W];
  assign o_block_addr = i_addr & BLOCK_MASK;

endmodule

// File: rtl/cache_read_controller.sv
// Direct-mapped read-only cache: hit returns the word, miss refills the whole block word 0 first.
module cache_read_controller
  import cache_pkg::*;
#(
  parameter int WORD_CAPACITY   = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_BITS       = 32,
  parameter int WORD_BITS       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_BITS-1:0] req_addr_i,
  output logic                 resp_valid_o,
  output logic [WORD_BITS-1:0] resp_data_o,
  input  logic                 flush_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [ADDR_BITS-1:0] mem_req_addr_o,
  input  logic                 mem_resp_valid_i,
  input  logic [WORD_BITS-1:0] mem_resp_data_i
);

  localparam int SET_COUNT = WORD_CAPACITY / WORDS_PER_BLOCK;
  localparam int SET_W     = set_idx_bits(WORD_CAPACITY, WORDS_PER_BLOCK);
  localparam int WORD_W    = word_idx_bits(WORDS_PER_BLOCK);
  localparam int BYTE_W    = byte_idx_bits(WORD_BITS);
  localparam int TAG_W     = ADDR_BITS - SET_W - WORD_W - BYTE_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLOCK - 1);

  cache_state_e r_state;
  cache_state_e w_state_next;

  logic [ADDR_BITS-1:0] r_addr;
  logic [WORD_W-1:0]    r_k;
  logic [SET_COUNT-1:0] r_valid;
  logic                 r_resp_valid;
  logic [WORD_BITS-1:0] r_resp_data;

  logic [TAG_W-1:0]     r_tag_mem  [SET_COUNT];
  logic [WORD_BITS-1:0] r_data_mem [SET_COUNT][WORDS_PER_BLOCK];

  logic [TAG_W-1:0]     w_tag;
  logic [SET_W-1:0]     w_set;
  logic [WORD_W-1:0]    w_word;
  logic [ADDR_BITS-1:0] w_block_addr;
  logic                 w_hit;
  logic                 w_accept;
  logic                 w_flush;
  logic                 w_respond;
  logic                 w_miss;
  logic                 w_fill_word;
  logic                 w_fill_last;

  cache_addr_decoder #(
    .ADDR_BITS      (ADDR_BITS),
    .WORD_BITS      (WORD_BITS),
    .WORD_CAPACITY  (WORD_CAPACITY),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_decoder (
    .i_addr      (r_addr),
    .o_tag       (w_tag),
    .o_set       (w_set),
    .o_word      (w_word),
    .o_block_addr(w_block_addr)
  );

  assign w_hit = r_valid[w_set] && (r_tag_mem[w_set] == w_tag);

  always_comb begin
    w_state_next    = r_state;
    req_ready_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    w_accept        = 1'b0;
    w_flush         = 1'b0;
    w_respond       = 1'b0;
    w_miss          = 1'b0;
    w_fill_word     = 1'b0;
    w_fill_last     = 1'b0;
    case (r_state)
      IDLE: begin
        // A flush takes the cycle; a coincident request is refused, not queued.
        req_ready_o = !flush_i;
        w_flush     = flush_i;
        if (req_valid_i && !flush_i) begin
          w_accept     = 1'b1;
          w_state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        w_respond    = w_hit;
        w_miss       = !w_hit;
        w_state_next = w_hit ? IDLE : MEM_REQ;
      end
      MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          w_state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_resp_valid_i) begin
          w_fill_word = 1'b1;
          if (r_k == LAST_WORD) begin
            w_fill_last  = 1'b1;
            w_state_next = LOOKUP;
          end else begin
            w_state_next = MEM_REQ;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr       <= '0;
      r_k          <= '0;
      r_valid      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_respond;
      if (w_respond) begin
        r_resp_data <= r_data_mem[w_set][w_word];
      end
      if (w_accept) begin
        r_addr <= req_addr_i;
      end
      if (w_miss) begin
        r_k <= '0;
      end else if (w_fill_word && !w_fill_last) begin
        r_k <= r_k + 1'b1;
      end
      if (w_flush) begin
        r_valid <= '0;
      end else if (w_fill_last) begin
        r_valid[w_set] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (w_fill_word) begin
      r_data_mem[w_set][r_k] <= mem_resp_data_i;
    end
    if (w_fill_last) begin
      r_tag_mem[w_set] <= w_tag;
    end
  end

  assign resp_valid_o   = r_resp_valid;
  assign resp_data_o    = r_resp_data;
  assign mem_req_addr_o = w_block_addr | (ADDR_BITS'(r_k) << BYTE_W);

endmodule
